scs8hd_and4_dbnc: RTL

Sequential qualifier stage placed directly downstream of the 4-input AND cell.
- Consumes the AND4 output X, which is asynchronous to CLK and may glitch.
- Synchronises X, then debounces it: the filtered level changes only after the synchronised value has held its new state for FILT_LEN consecutive enabled cycles.
- Produces a clean level plus single-cycle rise/fall pulses for downstream control logic.

---
 rtl/scs8hd_and4_dbnc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/scs8hd_and4_dbnc.sv
// Synchronises and debounces the asynchronous AND4 output, producing a clean
// level, single-cycle rise/fall pulses and the live debounce count.
module scs8hd_and4_dbnc #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 4
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             DIN,
  input  logic             EN,
  output logic             Q,
  output logic             ROSE,
  output logic             FELL,
  output logic [CNT_W-1:0] CNT
);

  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_e;

  // Last count value before the filter length is reached; CNT never exceeds it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rose_q, rose_d;
  logic                   fell_q, fell_d;
  logic                   q_int;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= DIN;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= LOW;
      cnt_q   <= '0;
      rose_q  <= 1'b0;
      fell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rose_q  <= rose_d;
      fell_q  <= fell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rose_d  = 1'b0;
    fell_d  = 1'b0;
    if (EN) begin
      case (state_q)
        LOW: begin
          if (s) begin
            if (FILT_LEN == 1) begin
              state_d = HIGH;
              cnt_d   = '0;
              rose_d  = 1'b1;
            end else begin
              state_d = RISE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        RISE: begin
          if (!s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            rose_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            if (FILT_LEN == 1) begin
              state_d = LOW;
              cnt_d   = '0;
              fell_d  = 1'b1;
            end else begin
              state_d = FALL;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        FALL: begin
          if (s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            fell_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign q_int = (state_q == HIGH) || (state_q == FALL);

`ifdef SC_USE_PG_PIN
  // Outputs are undefined unless the cell is properly powered.
  logic pg_ok;
  assign pg_ok = (vpwr == 1'b1) && (vgnd == 1'b0);
  assign Q    = pg_ok ? q_int  : 1'bx;
  assign ROSE = pg_ok ? rose_q : 1'bx;
  assign FELL = pg_ok ? fell_q : 1'bx;
  assign CNT  = pg_ok ? cnt_q  : {CNT_W{1'bx}};
`else
  assign Q    = q_int;
  assign ROSE = rose_q;
  assign FELL = fell_q;
  assign CNT  = cnt_q;
`endif

endmodule
